line_scan_decoder: RTL and testbench

LINE_SCAN_DECODER -- requirements
Module: line_scan_decoder

---
 rtl/line_scan_decoder.sv | 111 +++++++++++
 tb/tb_line_scan_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/line_scan_decoder.sv
// Direct N-to-2^N one-hot line decoder with a dwell-timed scan sequencer.
// Define LINE_SCAN_LOOP_EN for a continuously wrapping scan instead of one-shot.
module line_scan_decoder #(
   parameter int unsigned N       = 3,
   parameter int unsigned DWELL_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         a,
   input  logic                 e,
   input  logic                 mode,
   input  logic                 start,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [(1<<N)-1:0]    d,
   output logic [N-1:0]         cur,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned LINES = 1 << N;
   localparam logic [N-1:0] LAST = N'(LINES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

   state_t             state, state_nxt;
   logic [LINES-1:0]   d_nxt;
   logic [N-1:0]       cur_nxt;
   logic               busy_nxt, done_nxt;
   logic [DWELL_W-1:0] dcnt, dcnt_nxt;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         d     <= '0;
         cur   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         d     <= d_nxt;
         cur   <= cur_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   // Next-state and next-output logic; d defaults low so at most one line is ever high
   always_comb begin
      state_nxt = state;
      d_nxt     = '0;
      cur_nxt   = cur;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      dcnt_nxt  = dcnt;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (!mode) begin
               cur_nxt = a;
               if (e) d_nxt = LINES'(1) << a;
            end else if (start && e) begin
               state_nxt = SCAN;
               cur_nxt   = '0;
               dcnt_nxt  = dwell;
               d_nxt     = LINES'(1);
               busy_nxt  = 1'b1;
            end
         end
         SCAN: begin
            if (!mode) begin
               // Abort: one blank cycle, then direct decode from IDLE
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else if (e) begin
               if (dcnt != '0) begin
                  dcnt_nxt = dcnt - DWELL_W'(1);
                  d_nxt    = LINES'(1) << cur;
               end else if (cur == LAST) begin
`ifdef LINE_SCAN_LOOP_EN
                  cur_nxt  = '0;
                  dcnt_nxt = dwell;
                  d_nxt    = LINES'(1);
                  done_nxt = 1'b1;
`else
                  state_nxt = FIN;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
`endif
               end else begin
                  cur_nxt  = cur + N'(1);
                  dcnt_nxt = dwell;
                  d_nxt    = LINES'(1) << (cur + N'(1));
               end
            end
            // e low: d stays low, cur and dcnt hold
         end
         FIN: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_line_scan_decoder.sv
// Directed self-checking bench for line_scan_decoder (N=3, DWELL_W=4).
module tb_line_scan_decoder;

   logic       clk;
   logic       rst_n;
   logic [2:0] a;
   logic       e;
   logic       mode;
   logic       start;
   logic [3:0] dwell;
   logic [7:0] d;
   logic [2:0] cur;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   line_scan_decoder #(.N(3), .DWELL_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .e     (e),
      .mode  (mode),
      .start (start),
      .dwell (dwell),
      .d     (d),
      .cur   (cur),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; a = '0; e = 1'b0; mode = 1'b0; start = 1'b0; dwell = '0;
      #3;
      chk("rst_d", 32'(d), 32'h0);
      chk("rst_cur", 32'(cur), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      tick(); tick();
      rst_n = 1'b1;

      // Direct decode, latency 1
      mode = 1'b0; e = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         tick();
         chk("dir_d", 32'(d), 32'(1) << i);
         chk("dir_cur", 32'(cur), 32'(i));
      end
      e = 1'b0;
      tick();
      chk("dir_e0", 32'(d), 32'h0);

      // Idle in scan mode without start
      mode = 1'b1; e = 1'b1; a = 3'd5;
      tick();
      chk("idle_d", 32'(d), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);

      // start with e low is ignored
      e = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; e = 1'b1;
      tick();
      chk("start_e0_busy", 32'(busy), 32'h0);
      chk("start_e0_d", 32'(d), 32'h0);

      // One-shot scan, dwell=2 -> 3 cycles per line
      dwell = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int l = 0; l < 8; l++) begin
         for (int k = 0; k < 3; k++) begin
            chk("scan_d", 32'(d), 32'(1) << l);
            chk("scan_cur", 32'(cur), 32'(l));
            chk("scan_busy", 32'(busy), 32'h1);
            chk("scan_done", 32'(done), 32'h0);
            tick();
         end
      end
      chk("fin_d", 32'(d), 32'h0);
      chk("fin_done", 32'(done), 32'h1);
      chk("fin_busy", 32'(busy), 32'h0);
      tick();
      chk("fin_done_pulse", 32'(done), 32'h0);
      chk("fin_idle_busy", 32'(busy), 32'h0);

      // Pause in line 2 with dwell=3
      dwell = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      chk("pause_entry_d", 32'(d), 32'h04);
      e = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("pause_d", 32'(d), 32'h0);
         chk("pause_cur", 32'(cur), 32'h2);
      end
      e = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("resume_d", 32'(d), 32'h04);
         chk("resume_cur", 32'(cur), 32'h2);
      end
      tick();
      chk("resume_next_d", 32'(d), 32'h08);

      // Second start mid-scan has no effect
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_d", 32'(d), 32'h08);
      chk("restart_cur", 32'(cur), 32'h3);
      for (int k = 0; k < 3; k++) tick();
      chk("line4_d", 32'(d), 32'h10);

      // Abort at line 4
      mode = 1'b0; a = 3'd6;
      tick();
      chk("abort_d", 32'(d), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      tick();
      chk("abort_dir_d", 32'(d), 32'h40);
      chk("abort_dir_cur", 32'(cur), 32'h6);
      chk("abort_no_done", 32'(done), 32'h0);

      // Reset mid-scan at line 5, dwell=0
      mode = 1'b1; dwell = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("pre_rst_d", 32'(d), 32'h20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_d", 32'(d), 32'h0);
      chk("mid_rst_cur", 32'(cur), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("post_rst_done", 32'(done), 32'h0);
         chk("post_rst_d", 32'(d), 32'h0);
      end

`ifdef LINE_SCAN_LOOP_EN
      // Continuous scan, dwell=0
      dwell = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         chk("loop_d", 32'(d), 32'(1) << (i % 8));
         chk("loop_done", 32'(done), ((i % 8) == 0 && i >= 8) ? 32'h1 : 32'h0);
         chk("loop_busy", 32'(busy), 32'h1);
         tick();
      end
      mode = 1'b0;
      tick();
      chk("loop_abort_busy", 32'(busy), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
